// File: rtl/telemetry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_pkg
//  Description : Shared types and constants for the telemetry scheduler.
//                Holds the arbiter state encoding, the serializer word length
//                and the fixed frame marker words used by the serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package telemetry_pkg;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    // Bits per serialized word
    localparam int WORD_BITS = 16;

    // Frame marker words
    localparam logic [15:0] SYNC_WORD   = 16'hEB90;
    localparam logic [15:0] IDLE_WORD   = 16'hB3A5;
    localparam logic [15:0] END_WORD_HI = 16'hC0FE;
    localparam logic [15:0] END_WORD_LO = 16'hD0CC;

endpackage : telemetry_pkg
`default_nettype wire

// File: rtl/telemetry_strobe_gen.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_strobe_gen
//  Description : Free-running pacing strobes for the telemetry serializer.
//                A half-bit cycle counter plus half flag produce the bit
//                toggle and bit strobes; a bit counter and a word counter
//                produce the word and frame-sync strobes. All strobes are
//                registered single-cycle pulses.
//  Ports       : clk_i       - system clock
//                rst_n_i     - asynchronous active-low reset
//                bittogce_o  - end of first half of each bit
//                bitce_o     - end of second half of each bit
//                wordce_o    - coincident with the bitce_o ending bit 15
//                syncce_o    - coincident with the wordce_o ending the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module telemetry_strobe_gen
    import telemetry_pkg::*;
#(
    parameter int HALFBIT_CLKS = 25,
    parameter int FRAME_WORDS  = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic bitce_o,
    output logic bittogce_o,
    output logic wordce_o,
    output logic syncce_o
);

    localparam int CYC_W = $clog2(HALFBIT_CLKS);
    localparam int BIT_W = $clog2(WORD_BITS);
    localparam int WRD_W = $clog2(FRAME_WORDS);

    logic [CYC_W-1:0] cyc_q,  cyc_d;
    logic             half_q, half_d;
    logic [BIT_W-1:0] bit_q,  bit_d;
    logic [WRD_W-1:0] word_q, word_d;
    logic             bittog_q, bitce_q, wordce_q, syncce_q;

    logic w_half_end;
    logic w_bit_end;
    logic w_word_end;
    logic w_frame_end;

    always_comb begin
        w_half_end  = (cyc_q == CYC_W'(HALFBIT_CLKS - 1));
        w_bit_end   = w_half_end && half_q;
        w_word_end  = w_bit_end && (bit_q == BIT_W'(WORD_BITS - 1));
        w_frame_end = w_word_end && (word_q == WRD_W'(FRAME_WORDS - 1));

        cyc_d  = w_half_end ? '0 : cyc_q + 1'b1;
        half_d = half_q ^ w_half_end;
        // Bit counter spans exactly one word, so it wraps naturally
        bit_d  = w_bit_end ? bit_q + 1'b1 : bit_q;
        word_d = word_q;
        if (w_word_end) begin
            word_d = w_frame_end ? '0 : word_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cyc_q    <= '0;
            half_q   <= 1'b0;
            bit_q    <= '0;
            word_q   <= '0;
            bittog_q <= 1'b0;
            bitce_q  <= 1'b0;
            wordce_q <= 1'b0;
            syncce_q <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            // First-half wrap gives the toggle strobe, second-half wrap the bit strobe
            bittog_q <= w_half_end && !half_q;
            bitce_q  <= w_bit_end;
            wordce_q <= w_word_end;
            syncce_q <= w_frame_end;
        end
    end

    assign bittogce_o = bittog_q;
    assign bitce_o    = bitce_q;
    assign wordce_o   = wordce_q;
    assign syncce_o   = syncce_q;

endmodule : telemetry_strobe_gen
`default_nettype wire

// File: rtl/telemetry_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : telemetry_scheduler
//  Description : Sequencer and round-robin arbiter for the telemetry
//                serializer. Generates the pacing strobes and grants the
//                serializer to one of NBUF buffer requesters at a time:
//                one start pulse per grant, then waits for done.
//  Build macro : TELEM_TIMEOUT_EN - aborts a transfer after TIMEOUT_WORDS
//                words in BUSY (gen_rst_o pulse, then ack_o with err_o).
//  Ports       : clk_i, rst_n_i          - clock, async active-low reset
//                en_i                    - grant enable
//                req_i[NBUF]             - level requests, held until ack
//                ack_o[NBUF], err_o      - transfer completion / timeout
//                sel_o                   - granted buffer index
//                busy_o, start_o, done_i - serializer handshake
//                gen_rst_o               - serializer sync reset
//                bitce_o, bittogce_o,
//                wordce_o, syncce_o      - serializer strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module telemetry_scheduler
    import telemetry_pkg::*;
#(
    parameter int HALFBIT_CLKS  = 25,
    parameter int FRAME_WORDS   = 64,
    parameter int NBUF          = 2,
    parameter int TIMEOUT_WORDS = 4096,
    localparam int SEL_W        = (NBUF > 1) ? $clog2(NBUF) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [NBUF-1:0]  req_i,
    output logic [NBUF-1:0]  ack_o,
    output logic             err_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             start_o,
    input  logic             done_i,
    output logic             gen_rst_o,
    output logic             bitce_o,
    output logic             bittogce_o,
    output logic             wordce_o,
    output logic             syncce_o
);

    localparam int IDX_W = SEL_W + 1;

    logic w_wordce;

    telemetry_strobe_gen #(
        .HALFBIT_CLKS (HALFBIT_CLKS),
        .FRAME_WORDS  (FRAME_WORDS)
    ) u_strobe_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .bitce_o    (bitce_o),
        .bittogce_o (bittogce_o),
        .wordce_o   (w_wordce),
        .syncce_o   (syncce_o)
    );

    assign wordce_o = w_wordce;

    arb_state_e       state_q,   state_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic [SEL_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic             start_q,   start_d;
    logic             busy_q,    busy_d;
    logic [NBUF-1:0]  ack_q,     ack_d;
    logic             gen_rst_q, gen_rst_d;

    logic             w_found;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_next_ptr;
    logic [NBUF-1:0]  w_ack_vec;

    // Round-robin search: first active request at or above rr_ptr, with wrap
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = '0;
        for (int i = 0; i < NBUF; i++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NBUF)) begin
                idx = idx - IDX_W'(NBUF);
            end
            if (!w_found && req_i[idx[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = idx[SEL_W-1:0];
            end
        end
    end

    assign w_next_ptr = (sel_q == SEL_W'(NBUF - 1)) ? '0 : sel_q + 1'b1;
    assign w_ack_vec  = {{(NBUF-1){1'b0}}, 1'b1} << sel_q;

`ifdef TELEM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_WORDS > 1) ? $clog2(TIMEOUT_WORDS) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            tout_q,   tout_d;
    logic            err_q,    err_d;
`endif

    // Outputs are registered from the current state, so every handshake
    // output lags its state by one cycle (start_o appears in the first BUSY
    // cycle, ack_o in the cycle after ACK).
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        gen_rst_d = 1'b0;
        start_d   = (state_q == ST_START);
        busy_d    = (state_q == ST_START) || (state_q == ST_BUSY);
        ack_d     = (state_q == ST_ACK) ? w_ack_vec : '0;
`ifdef TELEM_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        tout_d    = tout_q;
        err_d     = (state_q == ST_ACK) && tout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_i && w_found) begin
                    state_d = ST_START;
                    sel_d   = w_grant;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
`ifdef TELEM_TIMEOUT_EN
                to_cnt_d = '0;
                tout_d   = 1'b0;
`endif
            end
            ST_BUSY: begin
                // done_i has priority over a timeout in the same cycle
                if (done_i) begin
                    state_d = ST_ACK;
                end
`ifdef TELEM_TIMEOUT_EN
                else if (w_wordce) begin
                    if (to_cnt_q == TO_W'(TIMEOUT_WORDS - 1)) begin
                        state_d   = ST_ACK;
                        tout_d    = 1'b1;
                        gen_rst_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                rr_ptr_d = w_next_ptr;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
            // Serializer is held in reset until the first edge after release
            gen_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            gen_rst_q <= gen_rst_d;
        end
    end

`ifdef TELEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q <= '0;
            tout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            tout_q   <= tout_d;
            err_q    <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_WORDS != 0);
    assign err_o        = 1'b0;
`endif

    assign sel_o     = sel_q;
    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign ack_o     = ack_q;
    assign gen_rst_o = gen_rst_q;

endmodule : telemetry_scheduler
`default_nettype wire

// File: tb/tb_telemetry_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_telemetry_scheduler
//  Description : Self-checking bench for telemetry_scheduler. A timestamp
//                model derives every output from the edge count since reset
//                release and the sampled inputs; directed phases add literal
//                expectations, followed by a randomized requester phase.
//                Build with TELEM_TIMEOUT_EN to exercise the timeout path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_telemetry_scheduler;

    localparam int H         = 2;
    localparam int FW        = 4;
    localparam int NB        = 4;
    localparam int TW        = 3;
    localparam int BIT_CYC   = 2 * H;
    localparam int WORD_CYC  = 32 * H;
    localparam int FRAME_CYC = WORD_CYC * FW;
`ifdef TELEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [NB-1:0] req;
    logic          done;
    logic [NB-1:0] ack;
    logic          err;
    logic [1:0]    sel;
    logic          busy, start, gen_rst, bitce, btog, wordce, syncce;

    telemetry_scheduler #(
        .HALFBIT_CLKS  (H),
        .FRAME_WORDS   (FW),
        .NBUF          (NB),
        .TIMEOUT_WORDS (TW)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .req_i      (req),
        .ack_o      (ack),
        .err_o      (err),
        .sel_o      (sel),
        .busy_o     (busy),
        .start_o    (start),
        .done_i     (done),
        .gen_rst_o  (gen_rst),
        .bitce_o    (bitce),
        .bittogce_o (btog),
        .wordce_o   (wordce),
        .syncce_o   (syncce)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: everything is a timestamp in edges since release
    // ------------------------------------------------------------------
    int n, m_ptr, m_sel, m_start, m_ack, m_grst, m_elig, m_words, m_idx;
    bit m_active, m_err, m_found, w_prev;

    task automatic model_reset();
        n = 0; m_ptr = 0; m_sel = 0; m_start = -1; m_ack = -1; m_grst = -1;
        m_elig = 1; m_words = 0; m_active = 1'b0; m_err = 1'b0;
    endtask

    initial begin
        logic        e_start, e_busy, e_err;
        logic [31:0] e_ack;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                n++;
                w_prev = (n > 1) && (((n - 1) % WORD_CYC) == 0);
                if (!m_active) begin
                    if (n >= m_elig && en && req != '0) begin
                        m_found = 1'b0;
                        for (int i = 0; i < NB; i++) begin
                            m_idx = (m_ptr + i) % NB;
                            if (!m_found && req[m_idx]) begin
                                m_found = 1'b1;
                                m_sel   = m_idx;
                            end
                        end
                        m_active = 1'b1; m_start = n + 1; m_ack = -1;
                        m_grst = -1; m_words = 0; m_err = 1'b0;
                    end
                end else if (m_ack < 0) begin
                    if (n >= m_start + 1) begin
                        if (done) begin
                            m_ack = n + 1;
                        end else if (TO_EN && w_prev) begin
                            m_words++;
                            if (m_words == TW) begin
                                m_grst = n; m_ack = n + 1; m_err = 1'b1;
                            end
                        end
                    end
                end else if (n == m_ack) begin
                    m_ptr = (m_sel + 1) % NB; m_active = 1'b0; m_elig = n + 1;
                end
                #1;
                if (rst_n) begin
                    e_start = (n == m_start);
                    e_busy  = m_active && (n >= m_start) && (m_ack < 0 || n < m_ack);
                    e_ack   = (m_ack >= 0 && n == m_ack) ? (32'd1 << m_sel) : 32'd0;
                    e_err   = (e_ack != 0) && m_err;
                    chk("bittogce", btog,   (n % BIT_CYC) == H);
                    chk("bitce",    bitce,  (n % BIT_CYC) == 0);
                    chk("wordce",   wordce, (n % WORD_CYC) == 0);
                    chk("syncce",   syncce, (n % FRAME_CYC) == 0);
                    chk("strobe_excl", btog & bitce, 0);
                    chk("start",    start,   e_start);
                    chk("busy",     busy,    e_busy);
                    chk("ack",      ack,     e_ack);
                    chk("err",      err,     e_err);
                    chk("gen_rst",  gen_rst, n == m_grst);
                    if (e_busy || e_ack != 0) chk("sel", sel, m_sel);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic chk_reset_outs();
        chk("rst_start", start, 0);   chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);       chk("rst_err", err, 0);
        chk("rst_sel", sel, 0);       chk("rst_gen_rst", gen_rst, 1);
        chk("rst_bitce", bitce, 0);   chk("rst_btog", btog, 0);
        chk("rst_wordce", wordce, 0); chk("rst_syncce", syncce, 0);
    endtask

    // Called mid-cycle; asserts reset asynchronously and releases on a negedge
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset_outs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("gen_rst_hold", gen_rst, 1);
    endtask

    task automatic wait_start(output logic [1:0] s);
        bit ok = 1'b0;
        int k  = 0;
        while (!ok && k < 400) begin
            @(posedge clk); #1;
            ok = start;
            k++;
        end
        s = sel;
        chk("start_seen", ok, 1);
    endtask

    task automatic wait_ack(input logic [NB-1:0] exp);
        bit ok = 1'b0;
        int k  = 0;
        while (!ok && k < 400) begin
            @(posedge clk); #1;
            ok = (ack != '0);
            k++;
        end
        chk("ack_seen", ok, 1);
        chk("ack_value", ack, exp);
    endtask

    task automatic pulse_done();
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c_btog, c_bit, c_word, c_sync, first_btog, wc, starts;
        logic [1:0]  s;
        int          rr[5];
        int          exp_rr[5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b1; en = 1'b0; req = '0; done = 1'b0;
        do_reset();

        // Strobe cadence over one frame, counted from the first edge
        c_btog = 0; c_bit = 0; c_word = 0; c_sync = 0; first_btog = 0;
        for (int i = 1; i <= FRAME_CYC; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("gen_rst_release", gen_rst, 0);
            if (btog && first_btog == 0) first_btog = i;
            c_btog += int'(btog); c_bit += int'(bitce);
            c_word += int'(wordce); c_sync += int'(syncce);
        end
        chk("first_btog", first_btog, H);
        chk("cnt_btog", c_btog, 64);
        chk("cnt_bitce", c_bit, 64);
        chk("cnt_wordce", c_word, 4);
        chk("cnt_syncce", c_sync, 1);

        // Single request
        @(negedge clk); en = 1'b1; req = 4'b0001;
        @(posedge clk);
        @(posedge clk); #1;
        chk("single_start", start, 1);
        chk("single_sel", sel, 0);
        @(negedge clk); done = 1'b1;
        @(posedge clk); #1;
        chk("single_busy_before_ack", busy, 1);
        chk("single_no_ack_yet", ack, 0);
        @(negedge clk); done = 1'b0;
        @(posedge clk); #1;
        chk("single_ack", ack, 4'b0001);
        chk("single_busy_at_ack", busy, 0);
        @(negedge clk); req = '0;

        // Disabled grants
        @(negedge clk); en = 1'b0; req = 4'b1111;
        starts = 0;
        repeat (40) begin
            @(posedge clk); #1;
            starts += int'(start);
        end
        chk("en0_no_start", starts, 0);

        // Round-robin from a fresh pointer
        @(negedge clk);
        do_reset();
        @(negedge clk); en = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_start(s);
            rr[g] = int'(s);
            pulse_done();
            wait_ack(4'b0001 << s);
        end
        for (int g = 0; g < 5; g++) chk("rr_order", rr[g], exp_rr[g]);
        @(negedge clk); req = '0; en = 1'b0;

        // Asynchronous reset in the middle of a transfer
        @(negedge clk); req = 4'b0001; en = 1'b1;
        wait_start(s);
        repeat (3) @(posedge clk);
        @(negedge clk);
        do_reset();
        @(posedge clk); #1;
        chk("regrant_gen_rst", gen_rst, 0);
        wait_start(s);
        chk("regrant_sel", s, 0);
        pulse_done();
        wait_ack(4'b0001);
        @(negedge clk); req = '0;

`ifdef TELEM_TIMEOUT_EN
        // Timeout with no done
        @(negedge clk); req = 4'b0010;
        wait_start(s);
        wc = int'(wordce);
        begin
            int k = 0;
            while (!gen_rst && k < 400) begin
                @(posedge clk); #1;
                if (!gen_rst) wc += int'(wordce);
                k++;
            end
        end
        chk("to_gen_rst_seen", gen_rst, 1);
        chk("to_words", wc, TW);
        @(posedge clk); #1;
        chk("to_ack", ack, 4'b0010);
        chk("to_err", err, 1);
        @(negedge clk); req = '0;

        // done_i in the same cycle as the timeout
        @(negedge clk); req = 4'b0100;
        wait_start(s);
        wc = int'(wordce);
        begin
            int k = 0;
            while (wc < TW && k < 400) begin
                @(posedge clk); #1;
                wc += int'(wordce);
                k++;
            end
        end
        chk("coinc_words", wc, TW);
        @(negedge clk); done = 1'b1;
        @(posedge clk); #1;
        chk("coinc_gen_rst", gen_rst, 0);
        @(negedge clk); done = 1'b0;
        @(posedge clk); #1;
        chk("coinc_ack", ack, 4'b0100);
        chk("coinc_err", err, 0);
        @(negedge clk); req = '0;
`else
        // Without the timeout feature BUSY waits indefinitely
        @(negedge clk); req = 4'b0010;
        wait_start(s);
        wc = 0;
        repeat (100 * WORD_CYC) begin
            @(posedge clk); #1;
            wc += int'(ack != '0) + int'(gen_rst);
        end
        chk("hold_busy", busy, 1);
        chk("hold_no_ack", wc, 0);
        pulse_done();
        wait_ack(4'b0010);
        @(negedge clk); req = '0;
`endif

        // Randomized requesters, enable and done
        repeat (3000) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                if (ack[b]) req[b] = 1'b0;
                else if (!req[b] && ($urandom % 6) == 0) req[b] = 1'b1;
            end
            en   = ($urandom % 10) != 0;
            done = ($urandom % 5) == 0;
        end
        @(negedge clk); done = 1'b0; req = '0;
        repeat (5) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_telemetry_scheduler
`default_nettype wire
